stage_mem: RTL and testbench

//  Memory-access pipeline stage and MEM/WB pipeline register; sits between the EX/MEM register and stage_WB.

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/mem_load_ext.sv | 34 +++
 rtl/stage_mem.sv | 176 +++++++++++++++++
 tb/tb_stage_mem.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared load/store encodings, memory-stage state constants and access-size decode
// used by the memory-access pipeline stage.
package riscv_pkg;

    localparam int unsigned NUM_LANES = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef logic [0:0] mem_state_t;
    localparam mem_state_t IDLE     = 1'b0;
    localparam mem_state_t WAIT_RSP = 1'b1;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_t;

    // Reserved funct3 encodings fall back to a word access for both loads and stores.
    function automatic mem_size_t access_size(input logic is_store, input logic [2:0] f3);
        mem_size_t sz;
        if (is_store) begin
            case (f3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                F3_SW:   sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-data aligner: picks the addressed byte/half out of the read word and
// sign- or zero-extends it to the register width.
module mem_load_ext
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic [REG_WIDTH-1:0] rdata_i,
    input  logic [2:0]           funct3_i,
    input  logic [1:0]           off_i,
    output logic [REG_WIDTH-1:0] data_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata_i[8*off_i +: 8];
        lane_half = rdata_i[16*off_i[1] +: 16];
    end

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{(REG_WIDTH-8){lane_byte[7]}}, lane_byte};
            F3_LBU:  data_o = {{(REG_WIDTH-8){1'b0}}, lane_byte};
            F3_LH:   data_o = {{(REG_WIDTH-16){lane_half[15]}}, lane_half};
            F3_LHU:  data_o = {{(REG_WIDTH-16){1'b0}}, lane_half};
            F3_LW:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: issues loads/stores on a req/gnt/rvalid port,
// stalls while a transaction is outstanding and holds the MEM/WB pipeline register.
module stage_mem
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH     = 32,
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     EX_MEM_valid,
    input  logic                     EX_MEM_mem_rd,
    input  logic                     EX_MEM_mem_wr,
    input  logic [2:0]               EX_MEM_funct3,
    input  logic [REG_WIDTH-1:0]     EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0]     EX_MEM_rs2_data,
    input  logic [RF_ADDR_WIDTH-1:0] EX_MEM_rd_addr,
    input  logic                     EX_MEM_reg_wr,
    input  logic                     EX_MEM_reg_wb_sel,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [REG_WIDTH-1:0]     dmem_addr,
    output logic [REG_WIDTH-1:0]     dmem_wdata,
    output logic [3:0]               dmem_be,
    input  logic                     dmem_gnt,
    input  logic                     dmem_rvalid,
    input  logic [REG_WIDTH-1:0]     dmem_rdata,
    output logic                     mem_stall,
    output logic                     MEM_WB_valid,
    output logic                     MEM_WB_reg_wb_sel,
    output logic [REG_WIDTH-1:0]     MEM_WB_alu_out,
    output logic [REG_WIDTH-1:0]     MEM_WB_data_out,
    output logic [RF_ADDR_WIDTH-1:0] MEM_WB_rd_addr,
    output logic                     MEM_WB_reg_wr,
    output logic                     MEM_WB_misalign
);

    logic [1:0]           off;
    mem_size_t            size;
    logic                 mem_op;
    logic                 addr_misalign;
    logic                 misalign;
    logic                 access;
    logic                 done;
    logic [REG_WIDTH-1:0] load_data;

    mem_state_t state_q, state_d;

    logic                     mem_wb_valid_q,    mem_wb_valid_d;
    logic                     mem_wb_wb_sel_q,   mem_wb_wb_sel_d;
    logic [REG_WIDTH-1:0]     mem_wb_alu_out_q,  mem_wb_alu_out_d;
    logic [REG_WIDTH-1:0]     mem_wb_data_out_q, mem_wb_data_out_d;
    logic [RF_ADDR_WIDTH-1:0] mem_wb_rd_addr_q,  mem_wb_rd_addr_d;
    logic                     mem_wb_reg_wr_q,   mem_wb_reg_wr_d;
    logic                     mem_wb_misalign_q, mem_wb_misalign_d;

    always_comb begin
        off    = EX_MEM_alu_out[1:0];
        size   = access_size(EX_MEM_mem_wr, EX_MEM_funct3);
        mem_op = EX_MEM_mem_rd | EX_MEM_mem_wr;
    end

    always_comb begin
        addr_misalign = 1'b0;
        case (size)
            SZ_HALF: addr_misalign = off[0];
            SZ_WORD: addr_misalign = (off != 2'b00);
            default: addr_misalign = 1'b0;
        endcase
    end

    // Misalignment only matters for memory instructions; ALU results may be odd.
    always_comb begin
        misalign = mem_op & addr_misalign;
        access   = EX_MEM_valid & mem_op & ~misalign;
    end

    always_comb begin
        dmem_be    = '0;
        dmem_wdata = EX_MEM_rs2_data;
        case (size)
            SZ_BYTE: begin
                dmem_be    = 4'b0001 << off;
                dmem_wdata = {NUM_LANES{EX_MEM_rs2_data[7:0]}};
            end
            SZ_HALF: begin
                dmem_be    = 4'b0011 << off;
                dmem_wdata = {(NUM_LANES/2){EX_MEM_rs2_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'hF;
                dmem_wdata = EX_MEM_rs2_data;
            end
        endcase
    end

    always_comb begin
        dmem_we   = EX_MEM_mem_wr;
        dmem_addr = {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
        dmem_req  = reset_n & (state_q == IDLE) & access;
        done      = ((state_q == IDLE) & EX_MEM_mem_wr & dmem_gnt)
                  | ((state_q == WAIT_RSP) & dmem_rvalid);
        mem_stall = reset_n & access & ~done;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (dmem_req & dmem_gnt & EX_MEM_mem_rd) state_d = WAIT_RSP;
            WAIT_RSP: if (dmem_rvalid) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    mem_load_ext #(
        .REG_WIDTH(REG_WIDTH)
    ) u_load_ext (
        .rdata_i (dmem_rdata),
        .funct3_i(EX_MEM_funct3),
        .off_i   (off),
        .data_o  (load_data)
    );

    // A stalled stage emits a bubble but keeps the previous payload fields.
    always_comb begin
        mem_wb_valid_d    = 1'b0;
        mem_wb_wb_sel_d   = mem_wb_wb_sel_q;
        mem_wb_alu_out_d  = mem_wb_alu_out_q;
        mem_wb_data_out_d = mem_wb_data_out_q;
        mem_wb_rd_addr_d  = mem_wb_rd_addr_q;
        mem_wb_reg_wr_d   = mem_wb_reg_wr_q;
        mem_wb_misalign_d = mem_wb_misalign_q;
        if (!mem_stall) begin
            mem_wb_valid_d    = EX_MEM_valid;
            mem_wb_wb_sel_d   = EX_MEM_reg_wb_sel;
            mem_wb_alu_out_d  = EX_MEM_alu_out;
            mem_wb_data_out_d = (access & EX_MEM_mem_rd) ? load_data : '0;
            mem_wb_rd_addr_d  = EX_MEM_rd_addr;
            mem_wb_reg_wr_d   = EX_MEM_reg_wr & ~misalign;
            mem_wb_misalign_d = EX_MEM_valid & misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            mem_wb_valid_q    <= 1'b0;
            mem_wb_wb_sel_q   <= 1'b0;
            mem_wb_alu_out_q  <= '0;
            mem_wb_data_out_q <= '0;
            mem_wb_rd_addr_q  <= '0;
            mem_wb_reg_wr_q   <= 1'b0;
            mem_wb_misalign_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            mem_wb_valid_q    <= mem_wb_valid_d;
            mem_wb_wb_sel_q   <= mem_wb_wb_sel_d;
            mem_wb_alu_out_q  <= mem_wb_alu_out_d;
            mem_wb_data_out_q <= mem_wb_data_out_d;
            mem_wb_rd_addr_q  <= mem_wb_rd_addr_d;
            mem_wb_reg_wr_q   <= mem_wb_reg_wr_d;
            mem_wb_misalign_q <= mem_wb_misalign_d;
        end
    end

    always_comb begin
        MEM_WB_valid      = mem_wb_valid_q;
        MEM_WB_reg_wb_sel = mem_wb_wb_sel_q;
        MEM_WB_alu_out    = mem_wb_alu_out_q;
        MEM_WB_data_out   = mem_wb_data_out_q;
        MEM_WB_rd_addr    = mem_wb_rd_addr_q;
        MEM_WB_reg_wr     = mem_wb_reg_wr_q;
        MEM_WB_misalign   = mem_wb_misalign_q;
    end

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed scenarios plus random instruction stream checked
// against a byte-addressed memory model and expected MEM/WB contents.
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        EX_MEM_valid, EX_MEM_mem_rd, EX_MEM_mem_wr;
    logic [2:0]  EX_MEM_funct3;
    logic [31:0] EX_MEM_alu_out, EX_MEM_rs2_data;
    logic [4:0]  EX_MEM_rd_addr;
    logic        EX_MEM_reg_wr, EX_MEM_reg_wb_sel;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        MEM_WB_valid, MEM_WB_reg_wb_sel, MEM_WB_reg_wr, MEM_WB_misalign;
    logic [31:0] MEM_WB_alu_out, MEM_WB_data_out;
    logic [4:0]  MEM_WB_rd_addr;

    always #5 clk = ~clk;

    stage_mem #(
        .REG_WIDTH    (32),
        .RF_ADDR_WIDTH(5)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .EX_MEM_valid     (EX_MEM_valid),
        .EX_MEM_mem_rd    (EX_MEM_mem_rd),
        .EX_MEM_mem_wr    (EX_MEM_mem_wr),
        .EX_MEM_funct3    (EX_MEM_funct3),
        .EX_MEM_alu_out   (EX_MEM_alu_out),
        .EX_MEM_rs2_data  (EX_MEM_rs2_data),
        .EX_MEM_rd_addr   (EX_MEM_rd_addr),
        .EX_MEM_reg_wr    (EX_MEM_reg_wr),
        .EX_MEM_reg_wb_sel(EX_MEM_reg_wb_sel),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_be          (dmem_be),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .mem_stall        (mem_stall),
        .MEM_WB_valid     (MEM_WB_valid),
        .MEM_WB_reg_wb_sel(MEM_WB_reg_wb_sel),
        .MEM_WB_alu_out   (MEM_WB_alu_out),
        .MEM_WB_data_out  (MEM_WB_data_out),
        .MEM_WB_rd_addr   (MEM_WB_rd_addr),
        .MEM_WB_reg_wr    (MEM_WB_reg_wr),
        .MEM_WB_misalign  (MEM_WB_misalign)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0] mem_b [256];

    logic        exp_valid = 1'b0;
    logic        exp_wb_sel, exp_reg_wr, exp_mis;
    logic [31:0] exp_alu, exp_data;
    logic [4:0]  exp_rd;

    int          req_cycles;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int msize(input logic wr, input logic [2:0] f3);
        if (wr && f3[2]) return 4;
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem_b[a[7:0]];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return {rd_byte(w + 3), rd_byte(w + 2), rd_byte(w + 1), rd_byte(w)};
    endfunction

    // Little-endian read of the accessed bytes, then extension by size and signedness.
    function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3);
        int          size;
        logic [31:0] v;
        size = msize(1'b0, f3);
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(rd_byte(a + 32'(i))) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] val);
        for (int i = 0; i < 4; i++) mem_b[8'(a[7:0] + 8'(i))] = val[8*i +: 8];
    endtask

    task automatic check_wb();
        check_eq("wb_valid", 32'(MEM_WB_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("wb_alu_out",  MEM_WB_alu_out, exp_alu);
            check_eq("wb_data_out", MEM_WB_data_out, exp_data);
            check_eq("wb_rd_addr",  32'(MEM_WB_rd_addr), 32'(exp_rd));
            check_eq("wb_reg_wr",   32'(MEM_WB_reg_wr), 32'(exp_reg_wr));
            check_eq("wb_wb_sel",   32'(MEM_WB_reg_wb_sel), 32'(exp_wb_sel));
            check_eq("wb_misalign", 32'(MEM_WB_misalign), 32'(exp_mis));
        end
    endtask

    // Presents one instruction (entered and left at a negedge) and plays the memory slave.
    task automatic issue(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rdx,
                         input logic regwr, input logic wbsel, input int gnt_dly, input int rsp_dly,
                         output int stalls);
        int          size, off, gcnt, rcnt;
        logic        mis, acc, waiting, done, exp_req;
        logic [31:0] exp_wd;
        size = msize(wr, f3);
        off  = int'(addr[1:0]);
        mis  = (rd || wr) && ((off % size) != 0);
        acc  = v && (rd || wr) && !mis;
        case (size)
            1:       exp_wd = {4{rs2[7:0]}};
            2:       exp_wd = {2{rs2[15:0]}};
            default: exp_wd = rs2;
        endcase
        EX_MEM_valid = v;  EX_MEM_mem_rd = rd;  EX_MEM_mem_wr = wr;  EX_MEM_funct3 = f3;
        EX_MEM_alu_out = addr;  EX_MEM_rs2_data = rs2;  EX_MEM_rd_addr = rdx;
        EX_MEM_reg_wr = regwr;  EX_MEM_reg_wb_sel = wbsel;
        waiting = 1'b0;  done = 1'b0;  gcnt = 0;  rcnt = 0;  stalls = 0;  req_cycles = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            check_wb();
            dmem_gnt = 1'b0;
            if (waiting) begin
                dmem_rvalid = (rcnt == 0);
                dmem_rdata  = (rcnt == 0) ? word_at(addr) : $urandom;
                if (rcnt > 0) rcnt--;
            end else begin
                dmem_rvalid = ($urandom_range(0, 3) == 0);
                dmem_rdata  = $urandom;
            end
            #1;
            exp_req = acc && !waiting;
            check_eq("req", 32'(dmem_req), 32'(exp_req));
            if (exp_req) begin
                req_cycles++;
                check_eq("addr", dmem_addr, {addr[31:2], 2'b00});
                check_eq("we", 32'(dmem_we), 32'(wr));
                if (wr) begin
                    check_eq("be", 32'(dmem_be), 32'(((1 << size) - 1) << off));
                    check_eq("wdata", dmem_wdata, exp_wd);
                end
                last_be    = dmem_be;
                last_wdata = dmem_wdata;
                dmem_gnt   = (gcnt == gnt_dly);
                gcnt++;
            end
            #1;
            done = !acc || (exp_req && wr && dmem_gnt) || (waiting && dmem_rvalid);
            check_eq("stall", 32'(mem_stall), 32'(!done));
            if (exp_req && dmem_gnt && rd) begin
                waiting = 1'b1;
                rcnt    = rsp_dly;
            end
            if (exp_req && dmem_gnt && wr)
                for (int i = 0; i < size; i++) mem_b[8'(addr[7:0] + 8'(i))] = rs2[8*i +: 8];
            if (done) begin
                exp_valid  = v;
                exp_alu    = addr;
                exp_rd     = rdx;
                exp_wb_sel = wbsel;
                exp_reg_wr = regwr && !mis;
                exp_mis    = v && mis;
                exp_data   = (acc && rd) ? load_val(addr, f3) : 32'h0;
            end else begin
                exp_valid = 1'b0;
                stalls++;
            end
            @(negedge clk);
        end
        check_eq("issue_done", 32'(done), 32'd1);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        int st;
        for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
        reset_n = 1'b0;
        EX_MEM_valid = 1'b1;  EX_MEM_mem_rd = 1'b1;  EX_MEM_mem_wr = 1'b0;  EX_MEM_funct3 = 3'b010;
        EX_MEM_alu_out = 32'h100;  EX_MEM_rs2_data = '0;  EX_MEM_rd_addr = 5'd1;
        EX_MEM_reg_wr = 1'b1;  EX_MEM_reg_wb_sel = 1'b0;
        dmem_gnt = 1'b1;  dmem_rvalid = 1'b1;  dmem_rdata = 32'hFFFF_FFFF;

        // Reset: outputs quiet even with a pending access and a granting memory.
        @(negedge clk);
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        check_eq("rst_wb_valid", 32'(MEM_WB_valid), 32'd0);
        check_eq("rst_wb_alu", MEM_WB_alu_out, 32'd0);
        check_eq("rst_wb_data", MEM_WB_data_out, 32'd0);
        check_eq("rst_wb_rd", 32'(MEM_WB_rd_addr), 32'd0);
        check_eq("rst_wb_regwr", 32'(MEM_WB_reg_wr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;  dmem_gnt = 1'b0;  dmem_rvalid = 1'b0;

        set_word(32'h100, 32'hDEAD_BEEF);
        issue(1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd3, 1, 0, 0, 0, st);
        check_eq("t1_stall_cycles", 32'(st), 32'd1);
        check_eq("t1_data", MEM_WB_data_out, 32'hDEAD_BEEF);
        check_eq("t1_reg_wr", 32'(MEM_WB_reg_wr), 32'd1);

        set_word(32'h100, 32'h80FF_0000);
        issue(1, 1, 0, 3'b000, 32'h103, 32'h0, 5'd4, 1, 0, 1, 1, st);
        check_eq("t2_lb", MEM_WB_data_out, 32'hFFFF_FF80);
        issue(1, 1, 0, 3'b100, 32'h103, 32'h0, 5'd5, 1, 0, 0, 2, st);
        check_eq("t2_lbu", MEM_WB_data_out, 32'h0000_0080);
        issue(1, 1, 0, 3'b001, 32'h102, 32'h0, 5'd6, 1, 0, 0, 0, st);
        check_eq("t2_lh", MEM_WB_data_out, 32'hFFFF_80FF);

        issue(1, 0, 1, 3'b000, 32'h101, 32'h1234_5678, 5'd0, 0, 0, 3, 0, st);
        check_eq("t3_stall_cycles", 32'(st), 32'd3);
        check_eq("t3_req_cycles", 32'(req_cycles), 32'd4);
        check_eq("t3_be", 32'(last_be), 32'b0010);
        check_eq("t3_wdata", last_wdata, 32'h7878_7878);

        issue(1, 1, 0, 3'b010, 32'h102, 32'h0, 5'd7, 1, 0, 0, 0, st);
        check_eq("t4_req_cycles", 32'(req_cycles), 32'd0);
        check_eq("t4_stall_cycles", 32'(st), 32'd0);
        check_eq("t4_misalign", 32'(MEM_WB_misalign), 32'd1);
        check_eq("t4_reg_wr", 32'(MEM_WB_reg_wr), 32'd0);

        // Reset while a load waits for its response; the late rvalid must be ignored.
        EX_MEM_valid = 1'b1;  EX_MEM_mem_rd = 1'b1;  EX_MEM_mem_wr = 1'b0;
        EX_MEM_funct3 = 3'b010;  EX_MEM_alu_out = 32'h108;
        #1;
        dmem_gnt = 1'b1;
        check_eq("t5_req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        dmem_gnt = 1'b0;  reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;  dmem_rvalid = 1'b1;  dmem_rdata = 32'hA5A5_A5A5;
        #1;
        check_eq("t5_req_idle", 32'(dmem_req), 32'd1);
        check_eq("t5_stall", 32'(mem_stall), 32'd1);
        check_eq("t5_wb_valid", 32'(MEM_WB_valid), 32'd0);
        check_eq("t5_wb_data", MEM_WB_data_out, 32'd0);
        check_eq("t5_wb_alu", MEM_WB_alu_out, 32'd0);
        check_eq("t5_wb_regwr", 32'(MEM_WB_reg_wr), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        exp_valid = 1'b0;
        issue(1, 1, 0, 3'b010, 32'h108, 32'h0, 5'd9, 1, 0, 0, 0, st);

        issue(1, 1, 0, 3'b010, 32'h104, 32'h0, 5'd10, 1, 0, 0, 0, st);
        issue(1, 0, 0, 3'($urandom), 32'h0000_1234, 32'h0, 5'd11, 1, 1, 0, 0, st);
        check_eq("t6_stall_cycles", 32'(st), 32'd0);
        check_eq("t6_wb_valid", 32'(MEM_WB_valid), 32'd1);
        check_eq("t6_alu", MEM_WB_alu_out, 32'h0000_1234);
        check_eq("t6_wb_sel", 32'(MEM_WB_reg_wb_sel), 32'd1);
        check_eq("t6_data", MEM_WB_data_out, 32'd0);

        for (int n = 0; n < 400; n++) begin
            int          kind;
            logic        v, ld, sw;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            v    = ($urandom_range(0, 9) != 0);
            ld   = (kind < 4);
            sw   = (kind >= 4 && kind < 7);
            a    = (ld || sw) ? 32'h100 + 32'($urandom_range(0, 63)) : $urandom;
            issue(v, ld, sw, 3'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 2), st);
        end
        check_wb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
